// File: rtl/bus_pkg.sv
// Shared definitions for the data-bus initiator: access size codes, FSM states,
// bus widths and small request-classification helpers.
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SIZE_B) || (size == SIZE_H);
  endfunction

  // The reserved size code counts as misaligned so it can be rejected with an error.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lane[0];
      SIZE_W:  return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bus_lane_align.sv
// Byte-lane steering: extracts and extends sub-word loads from a bus word and
// merges sub-word store data into a previously read word (little-endian lanes).
module bus_lane_align
  import bus_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] store_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val   = rd_word[{lane, 3'b000} +: 8];
    half_val   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data  = rd_word;
    store_word = wr_data;
    case (size)
      SIZE_B: begin
        load_data  = {{24{~is_unsigned & byte_val[7]}}, byte_val};
        store_word = rd_word;
        store_word[{lane, 3'b000} +: 8] = wr_data[7:0];
      end
      SIZE_H: begin
        load_data  = {{16{~is_unsigned & half_val[15]}}, half_val};
        store_word = rd_word;
        store_word[{lane[1], 4'b0000} +: 16] = wr_data[15:0];
      end
      default: begin
        load_data  = rd_word;
        store_word = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/bus_initiator.sv
// Data-bus initiator: byte/half/word core requests to word-only bus accesses,
// with read-modify-write for sub-word stores. Define BUS_INIT_ALIGN_CHECK_EN to reject misaligned requests.
module bus_initiator #(
  parameter int ADDR_W = bus_pkg::ADDR_W,
  parameter int DATA_W = bus_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              bus_r_en,
  output logic [ADDR_W-1:0] bus_r_addr,
  input  logic [DATA_W-1:0] bus_r_data,
  output logic              bus_w_en,
  output logic [ADDR_W-1:0] bus_w_addr,
  output logic [DATA_W-1:0] bus_w_data
);

  import bus_pkg::*;

  state_t            state;
  logic              we_q;
  logic              unsigned_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wword_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;
`ifdef BUS_INIT_ALIGN_CHECK_EN
  logic              err_q;
`endif

  bus_lane_align u_lane_align (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (unsigned_q),
    .rd_word     (bus_r_data),
    .wr_data     (wword_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  // wword_q holds the raw store data until RD replaces it with the merged word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wword_q    <= '0;
      rdata_q    <= '0;
`ifdef BUS_INIT_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else if (clk_enable) begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            addr_q     <= req_addr;
            wword_q    <= req_wdata;
            rdata_q    <= '0;
`ifdef BUS_INIT_ALIGN_CHECK_EN
            err_q      <= 1'b0;
            if (is_misaligned(req_size, req_addr[1:0])) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else
`endif
            if (!req_we || is_sub_word(req_size)) state <= ST_RD;
            else                                  state <= ST_WR;
          end
        end
        ST_RD: begin
          if (we_q) begin
            wword_q <= store_word;
            state   <= ST_WR;
          end else begin
            rdata_q <= load_data;
            state   <= ST_RESP;
          end
        end
        ST_WR:   state <= ST_RESP;
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = rdata_q;
`ifdef BUS_INIT_ALIGN_CHECK_EN
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0;
`endif
  assign bus_r_en   = (state == ST_RD);
  assign bus_w_en   = (state == ST_WR);
  assign bus_r_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_w_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_w_data = wword_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed self-checking bench for bus_initiator with a timer-style responder
// (counter at 0x0, ctrl at 0x4, RAM word at 0x8).
module tb_bus_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_enable;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_r_en;
  logic [31:0] bus_r_addr;
  logic [31:0] bus_r_data;
  logic        bus_w_en;
  logic [31:0] bus_w_addr;
  logic [31:0] bus_w_data;

  logic [31:0] cnt_reg  = 32'h0;
  logic [31:0] ctrl_reg = 32'h0;
  logic [31:0] ram_reg  = 32'h0;
  int          wr_count = 0;
  logic        poke_en;
  logic [31:0] poke_addr;
  logic [31:0] poke_data;

  int tests_run    = 0;
  int tests_failed = 0;

  bus_initiator dut (
    .clk          (clk),
    .rst          (rst),
    .clk_enable   (clk_enable),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .bus_r_en     (bus_r_en),
    .bus_r_addr   (bus_r_addr),
    .bus_r_data   (bus_r_data),
    .bus_w_en     (bus_w_en),
    .bus_w_addr   (bus_w_addr),
    .bus_w_data   (bus_w_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (bus_r_addr)
      32'h0:   bus_r_data = cnt_reg;
      32'h4:   bus_r_data = ctrl_reg;
      32'h8:   bus_r_data = ram_reg;
      default: bus_r_data = 32'hDEAD_BEEF;
    endcase
  end

  // Responder shares clk_enable; pokes let the bench preload registers directly.
  always @(posedge clk) begin
    if (poke_en) begin
      case (poke_addr)
        32'h0:   cnt_reg  <= poke_data;
        32'h4:   ctrl_reg <= poke_data;
        default: ram_reg  <= poke_data;
      endcase
    end else if (clk_enable && bus_w_en) begin
      wr_count <= wr_count + 1;
      case (bus_w_addr)
        32'h0:   cnt_reg  <= bus_w_data;
        32'h4:   ctrl_reg <= bus_w_data;
        32'h8:   ram_reg  <= bus_w_data;
        default: ;
      endcase
    end
  end

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    poke_en   = 1'b1;
    poke_addr = addr;
    poke_data = data;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // Issues one request and observes it for a bounded number of cycles.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int n_rd, output int n_wr, output int n_both,
                         output logic [31:0] raddr_seen, output logic [31:0] waddr_seen,
                         output logic [31:0] wdata_seen);
    lat = -1; rdata = 'x; err = 'x; n_rd = 0; n_wr = 0; n_both = 0;
    raddr_seen = 'x; waddr_seen = 'x; wdata_seen = 'x;
    @(negedge clk);
    drive_req(we, size, uns, addr, wdata);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (bus_r_en && bus_w_en) n_both++;
      if (bus_r_en) begin n_rd++; raddr_seen = bus_r_addr; end
      if (bus_w_en) begin n_wr++; waddr_seen = bus_w_addr; wdata_seen = bus_w_data; end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    tests_run++; if (resp_rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 0", resp_rdata); end
    tests_run++; if (resp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", resp_err); end
    tests_run++; if ({bus_r_en, bus_w_en} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_bus_en: got %b expected 00", {bus_r_en, bus_w_en}); end
    tests_run++; if ({bus_r_addr, bus_w_addr, bus_w_data} !== 96'h0) begin tests_failed++; $display("[TB] FAIL reset_bus_addr_data: got %h %h %h expected 0", bus_r_addr, bus_w_addr, bus_w_data); end
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_word_load();
    int lat, n_rd, n_wr, n_both; logic [31:0] rdata, ra, wa, wd; logic err;
    poke(32'h4, 32'h1);
    run_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("[TB] FAIL word_load_latency: got %0d expected 2", lat); end
    tests_run++; if (n_rd !== 1 || ra !== 32'h4) begin tests_failed++; $display("[TB] FAIL word_load_read: got %0d reads at %h expected 1 at 00000004", n_rd, ra); end
    tests_run++; if (n_wr !== 0) begin tests_failed++; $display("[TB] FAIL word_load_no_write: got %0d expected 0", n_wr); end
    tests_run++; if (rdata !== 32'h1 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL word_load_rdata: got %h err %b expected 00000001 err 0", rdata, err); end
  endtask

  task automatic test_subword_load();
    int lat, n_rd, n_wr, n_both; logic [31:0] rdata, ra, wa, wd; logic err;
    poke(32'h8, 32'h0000_8000);
    run_req(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (rdata !== 32'hFFFF_FF80 || ra !== 32'h8) begin tests_failed++; $display("[TB] FAIL byte_load_signed: got %h addr %h expected ffffff80 addr 00000008", rdata, ra); end
    run_req(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (rdata !== 32'h0000_0080) begin tests_failed++; $display("[TB] FAIL byte_load_unsigned: got %h expected 00000080", rdata); end
    poke(32'h8, 32'hBEEF_0000);
    run_req(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (rdata !== 32'hFFFF_BEEF) begin tests_failed++; $display("[TB] FAIL half_load_signed: got %h expected ffffbeef", rdata); end
    run_req(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (rdata !== 32'h0000_00BE) begin tests_failed++; $display("[TB] FAIL byte_load_lane3: got %h expected 000000be", rdata); end
    run_req(1'b0, 2'b00, 1'b0, 32'h8, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (rdata !== 32'h0 || lat !== 2) begin tests_failed++; $display("[TB] FAIL byte_load_lane0: got %h lat %0d expected 00000000 lat 2", rdata, lat); end
  endtask

  task automatic test_subword_store();
    int lat, n_rd, n_wr, n_both, wc0; logic [31:0] rdata, ra, wa, wd; logic err;
    poke(32'h8, 32'h1122_3344);
    wc0 = wr_count;
    run_req(1'b1, 2'b00, 1'b0, 32'hA, 32'h0000_00AB, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (lat !== 3) begin tests_failed++; $display("[TB] FAIL byte_store_latency: got %0d expected 3", lat); end
    tests_run++; if (n_rd !== 1 || n_wr !== 1 || n_both !== 0) begin tests_failed++; $display("[TB] FAIL byte_store_accesses: got rd %0d wr %0d both %0d expected 1 1 0", n_rd, n_wr, n_both); end
    tests_run++; if (wd !== 32'h11AB_3344 || wa !== 32'h8) begin tests_failed++; $display("[TB] FAIL byte_store_wdata: got %h at %h expected 11ab3344 at 00000008", wd, wa); end
    tests_run++; if (rdata !== 32'h0 || ram_reg !== 32'h11AB_3344 || wr_count !== wc0 + 1) begin tests_failed++; $display("[TB] FAIL byte_store_result: got rdata %h ram %h writes %0d expected 0 11ab3344 %0d", rdata, ram_reg, wr_count - wc0, 1); end
    run_req(1'b1, 2'b01, 1'b0, 32'h8, 32'h5555_CAFE, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (wd !== 32'h11AB_CAFE || ram_reg !== 32'h11AB_CAFE) begin tests_failed++; $display("[TB] FAIL half_store_merge: got %h ram %h expected 11abcafe", wd, ram_reg); end
  endtask

  task automatic test_clk_enable();
    int wc0;
    poke(32'h0, 32'h0);
    wc0 = wr_count;
    @(negedge clk);
    drive_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_0010);
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if (bus_w_en !== 1'b1 || bus_w_addr !== 32'h0 || bus_w_data !== 32'h10) begin tests_failed++; $display("[TB] FAIL stall_wr_entry: got en %b addr %h data %h expected 1 0 10", bus_w_en, bus_w_addr, bus_w_data); end
    clk_enable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tests_run++; if (bus_w_en !== 1'b1 || resp_valid !== 1'b0 || wr_count !== wc0) begin tests_failed++; $display("[TB] FAIL stall_hold: got en %b resp %b writes %0d expected 1 0 0", bus_w_en, resp_valid, wr_count - wc0); end
    end
    clk_enable = 1'b1;
    @(negedge clk);
    tests_run++; if (resp_valid !== 1'b1 || bus_w_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_resume: got resp %b en %b expected 1 0", resp_valid, bus_w_en); end
    tests_run++; if (wr_count !== wc0 + 1 || cnt_reg !== 32'h10) begin tests_failed++; $display("[TB] FAIL stall_single_write: got writes %0d counter %h expected 1 00000010", wr_count - wc0, cnt_reg); end
  endtask

  task automatic test_reset_mid_op();
    int wc0; int saw_w, saw_resp;
    poke(32'h8, 32'h1122_3344);
    wc0 = wr_count; saw_w = 0; saw_resp = 0;
    @(negedge clk);
    drive_req(1'b1, 2'b00, 1'b0, 32'h8, 32'h0000_0077);
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if (bus_r_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_in_rd: got %b expected 1", bus_r_en); end
    #1 rst = 1'b1;
    #1;
    tests_run++; if (bus_r_en !== 1'b0 || bus_w_en !== 1'b0 || req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_async: got r %b w %b ready %b expected 0 0 1", bus_r_en, bus_w_en, req_ready); end
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus_w_en) saw_w++;
      if (resp_valid) saw_resp++;
    end
    tests_run++; if (saw_w !== 0 || saw_resp !== 0 || wr_count !== wc0) begin tests_failed++; $display("[TB] FAIL midrst_abandon: got w %0d resp %0d writes %0d expected 0 0 0", saw_w, saw_resp, wr_count - wc0); end
    tests_run++; if (ram_reg !== 32'h1122_3344 || req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_state: got ram %h ready %b expected 11223344 1", ram_reg, req_ready); end
  endtask

  task automatic test_align();
    int lat, n_rd, n_wr, n_both, wc0; logic [31:0] rdata, ra, wa, wd; logic err;
    poke(32'h0, 32'h1234_5678);
    poke(32'h4, 32'h0);
    wc0 = wr_count;
`ifdef BUS_INIT_ALIGN_CHECK_EN
    run_req(1'b0, 2'b01, 1'b1, 32'h3, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (err !== 1'b1 || rdata !== 32'h0 || lat !== 1) begin tests_failed++; $display("[TB] FAIL align_half_err: got err %b rdata %h lat %0d expected 1 0 1", err, rdata, lat); end
    tests_run++; if (n_rd !== 0 || n_wr !== 0) begin tests_failed++; $display("[TB] FAIL align_half_no_bus: got rd %0d wr %0d expected 0 0", n_rd, n_wr); end
    run_req(1'b1, 2'b10, 1'b0, 32'h6, 32'h0000_0077, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (err !== 1'b1 || n_wr !== 0 || wr_count !== wc0) begin tests_failed++; $display("[TB] FAIL align_word_store: got err %b wr %0d expected 1 0", err, n_wr); end
    run_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (err !== 1'b1 || n_rd !== 0) begin tests_failed++; $display("[TB] FAIL align_reserved: got err %b rd %0d expected 1 0", err, n_rd); end
    run_req(1'b0, 2'b01, 1'b1, 32'h2, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (err !== 1'b0 || rdata !== 32'h0000_1234) begin tests_failed++; $display("[TB] FAIL align_ok_half: got err %b rdata %h expected 0 00001234", err, rdata); end
`else
    run_req(1'b0, 2'b01, 1'b1, 32'h3, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (n_rd !== 1 || ra !== 32'h0 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL noalign_half_read: got rd %0d at %h err %b expected 1 at 0 err 0", n_rd, ra, err); end
    tests_run++; if (rdata !== 32'h0000_1234) begin tests_failed++; $display("[TB] FAIL noalign_half_rdata: got %h expected 00001234", rdata); end
    run_req(1'b1, 2'b11, 1'b0, 32'h4, 32'h0000_0077, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (lat !== 2 || n_rd !== 0 || n_wr !== 1 || ctrl_reg !== 32'h77) begin tests_failed++; $display("[TB] FAIL noalign_reserved_store: got lat %0d rd %0d wr %0d ctrl %h expected 2 0 1 00000077", lat, n_rd, n_wr, ctrl_reg); end
    run_req(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, lat, rdata, err, n_rd, n_wr, n_both, ra, wa, wd);
    tests_run++; if (ra !== 32'h4 || rdata !== 32'h77) begin tests_failed++; $display("[TB] FAIL noalign_word_lane0: got %h at %h expected 00000077 at 00000004", rdata, ra); end
`endif
  endtask

  task automatic test_back_to_back();
    poke(32'h8, 32'hA5A5_0001);
    @(negedge clk);
    drive_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b0 || bus_r_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_busy_rd: got ready %b r_en %b expected 0 1", req_ready, bus_r_en); end
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_0001) begin tests_failed++; $display("[TB] FAIL b2b_resp: got ready %b resp %b rdata %h expected 0 1 a5a50001", req_ready, resp_valid, resp_rdata); end
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b1 || bus_r_en !== 1'b0 || resp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle_gap: got ready %b r_en %b resp %b expected 1 0 0", req_ready, bus_r_en, resp_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if (bus_r_en !== 1'b1 || req_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_second_accept: got r_en %b ready %b expected 1 0", bus_r_en, req_ready); end
    @(negedge clk);
    tests_run++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hA5A5_0001) begin tests_failed++; $display("[TB] FAIL b2b_second_resp: got resp %b rdata %h expected 1 a5a50001", resp_valid, resp_rdata); end
  endtask

  initial begin
    rst          = 1'b1;
    clk_enable   = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    poke_en      = 1'b0;
    poke_addr    = 32'h0;
    poke_data    = 32'h0;
    test_reset();
    test_word_load();
    test_subword_load();
    test_subword_store();
    test_clk_enable();
    test_reset_mid_op();
    test_align();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
